div_radix2: RTL

Iterative 32-bit radix-2 restoring divider that feeds the ALU's DIV/DIVU path. The ALU holds `start_i` high, and stalls the pipeline, until this block pulses `ready_o`. The 64-bit `result_o` is then consumed as {HI, LO} = {remainder, quotient}. The block handles signed and unsigned operands, divide-by-zero and cancellation, and keeps one operation in flight at a time.

---
 rtl/div_radix2.sv | 99 +++++++++
 1 files changed

// File: rtl/div_radix2.sv
// div_radix2: iterative 32-bit radix-2 restoring divider, signed/unsigned, with
// divide-by-zero and annul handling. result_o = {remainder, quotient}.
`default_nettype none

module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BY_ZERO = 2'd1;
  localparam logic [1:0] ON      = 2'd2;
  localparam logic [1:0] END     = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [63:0] sh;
  logic [31:0] divisor;
  logic [31:0] a_lat;
  logic        neg_q;
  logic        neg_r;
  logic [63:0] result;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        ge;
  logic [31:0] trial;
  logic [63:0] sh_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    abs_a = (signed_div_i && a[31]) ? (~a + 32'd1) : a;
    abs_b = (signed_div_i && b[31]) ? (~b + 32'd1) : b;
    // sh[63:31] is the 33-bit partial remainder after the left shift
    ge      = (sh[63:31] >= {1'b0, divisor});
    trial   = sh[62:31] - divisor;
    sh_next = ge ? {trial, sh[30:0], 1'b1} : {sh[62:0], 1'b0};
    quo_fix = neg_q ? (32'd0 - sh_next[31:0])  : sh_next[31:0];
    rem_fix = neg_r ? (32'd0 - sh_next[63:32]) : sh_next[63:32];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      sh      <= 64'd0;
      divisor <= 32'd0;
      a_lat   <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            a_lat   <= a;
            sh      <= {32'd0, abs_a};
            divisor <= abs_b;
            neg_q   <= signed_div_i & (a[31] ^ b[31]);
            neg_r   <= signed_div_i & a[31];
            cnt     <= 5'd0;
            state   <= (b == 32'd0) ? BY_ZERO : ON;
          end
        end
        BY_ZERO: begin
          result <= {a_lat, 32'hFFFF_FFFF};
          state  <= END;
        end
        ON: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            sh  <= sh_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result <= {rem_fix, quo_fix};
              state  <= END;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result_o = result;
  assign ready_o  = (state == END);

endmodule

`default_nettype wire
